// File: rtl/axi_lite_req_arbiter.sv
`default_nettype none
// =============================================================================
// axi_lite_req_arbiter : round-robin share of one AXI-Lite master port among
// NUM_REQ command requesters, one single-beat transaction in flight at a time.
// Revision 1.0
// =============================================================================
module axi_lite_req_arbiter #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ    = 2
) (
   input  logic                              aclk,
   input  logic                              areset,
   input  logic [NUM_REQ-1:0]                req_valid,
   output logic [NUM_REQ-1:0]                req_ready,
   input  logic [NUM_REQ-1:0]                req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
   input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   req_wstrb,
   output logic [NUM_REQ-1:0]                rsp_valid,
   output logic [DATA_WIDTH-1:0]             rsp_rdata,
   output logic [1:0]                        rsp_resp,
   output logic [ADDR_WIDTH-1:0]             M_AXI_LITE_awaddr,
   output logic                              M_AXI_LITE_awvalid,
   input  logic                              M_AXI_LITE_awready,
   output logic [DATA_WIDTH-1:0]             M_AXI_LITE_wdata,
   output logic [DATA_WIDTH/8-1:0]           M_AXI_LITE_wstrb,
   output logic                              M_AXI_LITE_wvalid,
   input  logic                              M_AXI_LITE_wready,
   input  logic [1:0]                        M_AXI_LITE_bresp,
   input  logic                              M_AXI_LITE_bvalid,
   output logic                              M_AXI_LITE_bready,
   output logic [ADDR_WIDTH-1:0]             M_AXI_LITE_araddr,
   output logic                              M_AXI_LITE_arvalid,
   input  logic                              M_AXI_LITE_arready,
   input  logic [DATA_WIDTH-1:0]             M_AXI_LITE_rdata,
   input  logic [1:0]                        M_AXI_LITE_rresp,
   input  logic                              M_AXI_LITE_rvalid,
   output logic                              M_AXI_LITE_rready
);
   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int SW = DATA_WIDTH / 8;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WR   = 3'd1;
   localparam logic [2:0] S_WB   = 3'd2;
   localparam logic [2:0] S_RA   = 3'd3;
   localparam logic [2:0] S_RD   = 3'd4;
   localparam logic [2:0] S_RSP  = 3'd5;

   logic [2:0]            state_q, state_d;
   // last_q doubles as the owner of the in-flight transaction
   logic [GW-1:0]         last_q, last_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [SW-1:0]         wstrb_q, wstrb_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            resp_q, resp_d;
   logic                  awvalid_q, awvalid_d;
   logic                  wvalid_q, wvalid_d;
   logic                  arvalid_q, arvalid_d;

   logic [NUM_REQ-1:0]    grant_oh;
   logic [GW-1:0]         grant_idx;
   logic                  grant_any;
   logic [GW:0]           cand;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [SW-1:0]         sel_wstrb;
   logic                  sel_write;
   logic [NUM_REQ-1:0]    owner_oh;

   // Search upward from last_q+1 with wrap-around; first valid requester wins.
   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      cand      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = {1'b0, last_q} + (GW+1)'(k);
         if (cand >= (GW+1)'(NUM_REQ)) begin
            cand = cand - (GW+1)'(NUM_REQ);
         end
         if (!grant_any && req_valid[cand[GW-1:0]]) begin
            grant_any             = 1'b1;
            grant_idx             = cand[GW-1:0];
            grant_oh[cand[GW-1:0]] = 1'b1;
         end
      end
   end

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_wstrb = '0;
      sel_write = 1'b0;
      owner_oh  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_oh[i]) begin
            sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            sel_wstrb = req_wstrb[i*SW +: SW];
            sel_write = req_write[i];
         end
         owner_oh[i] = (last_q == GW'(i));
      end
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rdata_d   = rdata_q;
      resp_d    = resp_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      arvalid_d = arvalid_q;
      case (state_q)
         S_IDLE: begin
            if (grant_any) begin
               last_d  = grant_idx;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               wstrb_d = sel_wstrb;
               if (sel_write) begin
                  state_d   = S_WR;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = S_RA;
                  arvalid_d = 1'b1;
               end
            end
         end
         S_WR: begin
            // aw and w retire independently, in either order
            if (M_AXI_LITE_awready) awvalid_d = 1'b0;
            if (M_AXI_LITE_wready)  wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) state_d = S_WB;
         end
         S_WB: begin
            if (M_AXI_LITE_bvalid) begin
               resp_d  = M_AXI_LITE_bresp;
               rdata_d = '0;
               state_d = S_RSP;
            end
         end
         S_RA: begin
            if (M_AXI_LITE_arready) begin
               arvalid_d = 1'b0;
               state_d   = S_RD;
            end
         end
         S_RD: begin
            if (M_AXI_LITE_rvalid) begin
               resp_d  = M_AXI_LITE_rresp;
               rdata_d = M_AXI_LITE_rdata;
               state_d = S_RSP;
            end
         end
         S_RSP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q   <= S_IDLE;
         last_q    <= GW'(NUM_REQ - 1);
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         resp_q    <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         arvalid_q <= arvalid_d;
      end
   end

   // No accept while reset is asserted, even though the state already reads IDLE.
   assign req_ready          = (state_q == S_IDLE && !areset) ? grant_oh : '0;
   assign rsp_valid          = (state_q == S_RSP) ? owner_oh : '0;
   assign rsp_rdata          = rdata_q;
   assign rsp_resp           = resp_q;
   assign M_AXI_LITE_awaddr  = addr_q;
   assign M_AXI_LITE_araddr  = addr_q;
   assign M_AXI_LITE_wdata   = wdata_q;
   assign M_AXI_LITE_wstrb   = wstrb_q;
   assign M_AXI_LITE_awvalid = awvalid_q;
   assign M_AXI_LITE_wvalid  = wvalid_q;
   assign M_AXI_LITE_arvalid = arvalid_q;
   assign M_AXI_LITE_bready  = (state_q == S_WB);
   assign M_AXI_LITE_rready  = (state_q == S_RD);

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_req_arbiter.sv
`default_nettype none
// tb_axi_lite_req_arbiter: directed and randomized checks of the arbiter
// against an in-bench AXI-Lite slave and a transaction-level reference model.
module tb_axi_lite_req_arbiter;
   localparam int AW  = 4;
   localparam int DW  = 32;
   localparam int NR  = 2;
   localparam int SW  = DW / 8;
   localparam int NTX = 30;

   logic              aclk = 1'b0;
   logic              areset;
   logic [NR-1:0]     req_valid, req_ready, req_write, rsp_valid;
   logic [NR*AW-1:0]  req_addr;
   logic [NR*DW-1:0]  req_wdata;
   logic [NR*SW-1:0]  req_wstrb;
   logic [DW-1:0]     rsp_rdata;
   logic [1:0]        rsp_resp;
   logic [AW-1:0]     awaddr, araddr;
   logic [DW-1:0]     wdata, rdata;
   logic [SW-1:0]     wstrb;
   logic [1:0]        bresp, rresp;
   logic              awvalid, awready, wvalid, wready, bvalid, bready;
   logic              arvalid, arready, rvalid, rready;

   int n_chk = 0;
   int n_pass = 0;
   int exp_last;

   always #5 aclk = ~aclk;

   axi_lite_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
      .aclk(aclk), .areset(areset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .M_AXI_LITE_awaddr(awaddr), .M_AXI_LITE_awvalid(awvalid), .M_AXI_LITE_awready(awready),
      .M_AXI_LITE_wdata(wdata), .M_AXI_LITE_wstrb(wstrb), .M_AXI_LITE_wvalid(wvalid),
      .M_AXI_LITE_wready(wready), .M_AXI_LITE_bresp(bresp), .M_AXI_LITE_bvalid(bvalid),
      .M_AXI_LITE_bready(bready), .M_AXI_LITE_araddr(araddr), .M_AXI_LITE_arvalid(arvalid),
      .M_AXI_LITE_arready(arready), .M_AXI_LITE_rdata(rdata), .M_AXI_LITE_rresp(rresp),
      .M_AXI_LITE_rvalid(rvalid), .M_AXI_LITE_rready(rready)
   );

   // ---------------- AXI-Lite slave model ----------------
   logic [DW-1:0] init_mem [16];
   logic [DW-1:0] sl_mem   [16];
   int            aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
   bit            rand_mode = 1'b0;
   logic [1:0]    bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   int            aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
   bit            aw_have, w_have, b_pend, r_pend;
   logic [AW-1:0] aw_a;
   logic [DW-1:0] w_d, r_d;
   logic [SW-1:0] w_s;

   always @(posedge aclk) begin
      if (areset) begin
         aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
         aw_have = 0; w_have = 0; b_pend = 0; r_pend = 0;
         r_d = '0;
         for (int a = 0; a < 16; a++) sl_mem[a] = init_mem[a];
      end else begin
         if (bvalid && bready) b_pend = 0; else if (b_pend) b_cnt++;
         if (rvalid && rready) r_pend = 0; else if (r_pend) r_cnt++;
         if (awvalid && awready) begin aw_have = 1; aw_a = awaddr; aw_cnt = 0; end
         else if (awvalid) aw_cnt++;
         if (wvalid && wready) begin w_have = 1; w_d = wdata; w_s = wstrb; w_cnt = 0; end
         else if (wvalid) w_cnt++;
         if (arvalid && arready) begin r_pend = 1; r_cnt = 0; ar_cnt = 0; r_d = sl_mem[araddr]; end
         else if (arvalid) ar_cnt++;
         if (aw_have && w_have) begin
            for (int b = 0; b < SW; b++) if (w_s[b]) sl_mem[aw_a][b*8 +: 8] = w_d[b*8 +: 8];
            aw_have = 0; w_have = 0; b_pend = 1; b_cnt = 0;
         end
      end
   end

   always @(negedge aclk) begin
      awready = awvalid && !aw_have && (rand_mode ? ($urandom % 2 == 1) : (aw_cnt >= aw_wait));
      wready  = wvalid && !w_have && (rand_mode ? ($urandom % 2 == 1) : (w_cnt >= w_wait));
      arready = arvalid && !r_pend && (rand_mode ? ($urandom % 2 == 1) : (ar_cnt >= ar_wait));
      bvalid  = b_pend && (bvalid || (rand_mode ? ($urandom % 2 == 1) : (b_cnt >= b_wait)));
      rvalid  = r_pend && (rvalid || (rand_mode ? ($urandom % 2 == 1) : (r_cnt >= r_wait)));
      bresp   = bresp_cfg;
      rresp   = rresp_cfg;
      rdata   = rvalid ? r_d : '0;
   end

   // ---------------- helpers ----------------
   function automatic logic [NR-1:0] oh(input int j);
      return NR'(1) << j;
   endfunction

   task automatic step();
      @(negedge aclk);
      #1;
   endtask

   task automatic set_cmd(input int i, input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s);
      req_write[i] = wr;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
      req_wstrb[i*SW +: SW] = s;
      req_valid[i] = 1'b1;
   endtask

   task automatic wait_ready(input int limit, output logic [NR-1:0] seen);
      #1;
      seen = '0;
      for (int c = 0; c < limit && seen == '0; c++) begin
         if (req_ready != '0) seen = req_ready;
         else step();
      end
   endtask

   task automatic wait_rsp(input int limit, output logic [NR-1:0] seen);
      seen = '0;
      for (int c = 0; c < limit && seen == '0; c++) begin
         step();
         seen = rsp_valid;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      for (int a = 0; a < 16; a++) init_mem[a] = $urandom;
      init_mem[8]  = 32'h1234_5678;
      init_mem[0]  = 32'hA0A0_0000;
      init_mem[12] = 32'h0000_C0C0;
      areset = 1'b1; req_valid = '0; req_write = '0;
      req_addr = '0; req_wdata = '0; req_wstrb = '0;
      repeat (3) step();
      areset = 1'b0;
      step();
      exp_last = NR - 1;
      n_chk++; if (req_ready !== '0) $display("FAIL reset_ready: got %b exp 0", req_ready); else n_pass++;
      n_chk++; if (rsp_valid !== '0) $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); else n_pass++;
      n_chk++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0)
         $display("FAIL reset_axi_ctl: got %b exp 0", {awvalid, wvalid, bready, arvalid, rready}); else n_pass++;
      n_chk++; if ({awaddr, araddr, wdata, wstrb, rsp_rdata, rsp_resp} !== '0)
         $display("FAIL reset_payload: got %h exp 0", {awaddr, araddr, wdata, wstrb, rsp_rdata, rsp_resp}); else n_pass++;
   endtask

   task automatic test_single_write();
      logic [NR-1:0] seen;
      set_cmd(0, 1'b1, 4'h4, 32'hDEAD_BEEF, 4'hF);
      wait_ready(10, seen);
      n_chk++; if (seen !== 2'b01) $display("FAIL wr_accept: got %b exp 01", seen); else n_pass++;
      step(); req_valid[0] = 1'b0;
      n_chk++; if ({awvalid, wvalid, awaddr, wdata, wstrb} !== {2'b11, 4'h4, 32'hDEAD_BEEF, 4'hF})
         $display("FAIL wr_t1: got %h exp %h", {awvalid, wvalid, awaddr, wdata, wstrb},
                  {2'b11, 4'h4, 32'hDEAD_BEEF, 4'hF}); else n_pass++;
      step();
      n_chk++; if ({rsp_valid, bready} !== 3'b001) $display("FAIL wr_t2: got %b exp 001", {rsp_valid, bready}); else n_pass++;
      step();
      n_chk++; if ({rsp_valid, rsp_resp, rsp_rdata} !== {2'b01, 2'b00, 32'h0})
         $display("FAIL wr_rsp: got %h exp %h", {rsp_valid, rsp_resp, rsp_rdata}, {2'b01, 2'b00, 32'h0}); else n_pass++;
      exp_last = 0;
   endtask

   task automatic test_single_read();
      logic [NR-1:0] seen;
      r_wait = 3;
      set_cmd(1, 1'b0, 4'h8, '0, '0);
      wait_ready(10, seen);
      n_chk++; if (seen !== 2'b10) $display("FAIL rd_accept: got %b exp 10", seen); else n_pass++;
      step(); req_valid[1] = 1'b0;
      n_chk++; if ({arvalid, araddr} !== {1'b1, 4'h8}) $display("FAIL rd_ar: got %h exp %h", {arvalid, araddr}, {1'b1, 4'h8}); else n_pass++;
      repeat (4) step();
      n_chk++; if ({rsp_valid, rready} !== 3'b001) $display("FAIL rd_wait: got %b exp 001", {rsp_valid, rready}); else n_pass++;
      step();
      n_chk++; if ({rsp_valid, rsp_resp, rsp_rdata} !== {2'b10, 2'b00, 32'h1234_5678})
         $display("FAIL rd_rsp: got %h exp %h", {rsp_valid, rsp_resp, rsp_rdata}, {2'b10, 2'b00, 32'h1234_5678}); else n_pass++;
      r_wait = 0;
      exp_last = 1;
   endtask

   task automatic test_contention();
      logic [NR-1:0] seen;
      int            w;
      set_cmd(0, 1'b0, 4'h0, '0, '0);
      set_cmd(1, 1'b0, 4'hC, '0, '0);
      for (int n = 0; n < 4; n++) begin
         w = (exp_last + 1) % NR;
         wait_ready(20, seen);
         n_chk++; if (seen !== oh(w)) $display("FAIL cont_grant%0d: got %b exp %b", n, seen, oh(w)); else n_pass++;
         exp_last = w;
         wait_rsp(20, seen);
         n_chk++; if ({seen, rsp_rdata} !== {oh(w), init_mem[w == 0 ? 0 : 12]})
            $display("FAIL cont_rsp%0d: got %h exp %h", n, {seen, rsp_rdata}, {oh(w), init_mem[w == 0 ? 0 : 12]});
         else n_pass++;
      end
      req_valid = '0;
   endtask

   task automatic test_split_write();
      logic [NR-1:0] seen;
      w_wait = 3;
      set_cmd(0, 1'b1, 4'h2, 32'hA5A5_0F0F, 4'h3);
      wait_ready(10, seen);
      n_chk++; if (seen !== oh((exp_last + 1) % NR)) $display("FAIL split_accept: got %b exp %b", seen, oh((exp_last + 1) % NR)); else n_pass++;
      for (int t = 1; t <= 5; t++) begin
         step();
         if (t == 1) req_valid[0] = 1'b0;
         n_chk++; if ({awvalid, wvalid, bready} !== {t == 1, t <= 4, t == 5})
            $display("FAIL split_t%0d: got %b exp %b", t, {awvalid, wvalid, bready}, {t == 1, t <= 4, t == 5}); else n_pass++;
         if (t <= 4) begin
            n_chk++; if ({awaddr, wdata, wstrb} !== {4'h2, 32'hA5A5_0F0F, 4'h3})
               $display("FAIL split_data_t%0d: got %h exp %h", t, {awaddr, wdata, wstrb}, {4'h2, 32'hA5A5_0F0F, 4'h3}); else n_pass++;
         end
      end
      step();
      n_chk++; if ({rsp_valid, rsp_resp} !== {2'b01, 2'b00}) $display("FAIL split_rsp: got %b exp 0100", {rsp_valid, rsp_resp}); else n_pass++;
      w_wait = 0;
      exp_last = 0;
   endtask

   task automatic test_errors();
      logic [NR-1:0] seen;
      bresp_cfg = 2'b10; rresp_cfg = 2'b11;
      set_cmd(1, 1'b1, 4'h6, 32'h0BAD_F00D, 4'hF);
      wait_ready(10, seen);
      n_chk++; if (seen !== 2'b10) $display("FAIL err_wr_accept: got %b exp 10", seen); else n_pass++;
      step(); req_valid[1] = 1'b0;
      wait_rsp(20, seen);
      n_chk++; if ({seen, rsp_resp, rsp_rdata} !== {2'b10, 2'b10, 32'h0})
         $display("FAIL err_bresp: got %h exp %h", {seen, rsp_resp, rsp_rdata}, {2'b10, 2'b10, 32'h0}); else n_pass++;
      set_cmd(0, 1'b0, 4'h6, '0, '0);
      wait_ready(10, seen);
      n_chk++; if (seen !== 2'b01) $display("FAIL err_rd_accept: got %b exp 01", seen); else n_pass++;
      step(); req_valid[0] = 1'b0;
      wait_rsp(20, seen);
      n_chk++; if ({seen, rsp_resp, rsp_rdata} !== {2'b01, 2'b11, 32'h0BAD_F00D})
         $display("FAIL err_rresp: got %h exp %h", {seen, rsp_resp, rsp_rdata}, {2'b01, 2'b11, 32'h0BAD_F00D}); else n_pass++;
      bresp_cfg = 2'b00; rresp_cfg = 2'b00;
      exp_last = 0;
   endtask

   task automatic test_reset_mid();
      logic [NR-1:0] seen;
      r_wait = 1000;
      set_cmd(0, 1'b0, 4'h1, '0, '0);
      wait_ready(10, seen);
      n_chk++; if (seen !== 2'b01) $display("FAIL rst_accept: got %b exp 01", seen); else n_pass++;
      step(); req_valid[0] = 1'b0;
      step();
      n_chk++; if (rready !== 1'b1) $display("FAIL rst_in_rd: got %b exp 1", rready); else n_pass++;
      set_cmd(1, 1'b0, 4'hC, '0, '0);
      areset = 1'b1;
      step();
      n_chk++; if ({req_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready} !== '0)
         $display("FAIL rst_ctl: got %b exp 0", {req_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready}); else n_pass++;
      n_chk++; if ({awaddr, wdata, wstrb, rsp_rdata, rsp_resp} !== '0)
         $display("FAIL rst_payload: got %h exp 0", {awaddr, wdata, wstrb, rsp_rdata, rsp_resp}); else n_pass++;
      areset = 1'b0; r_wait = 0;
      wait_ready(10, seen);
      n_chk++; if (seen !== 2'b10) $display("FAIL rst_req1_first: got %b exp 10", seen); else n_pass++;
      step(); req_valid[1] = 1'b0;
      wait_rsp(20, seen);
      n_chk++; if ({seen, rsp_rdata} !== {2'b10, init_mem[12]})
         $display("FAIL rst_req1_rsp: got %h exp %h", {seen, rsp_rdata}, {2'b10, init_mem[12]}); else n_pass++;
      // Make requester 0 the last grant, then show reset restores the priority pointer.
      set_cmd(0, 1'b0, 4'h0, '0, '0);
      wait_ready(10, seen);
      step(); req_valid[0] = 1'b0;
      wait_rsp(20, seen);
      areset = 1'b1;
      set_cmd(0, 1'b0, 4'h0, '0, '0);
      set_cmd(1, 1'b0, 4'h4, '0, '0);
      step();
      areset = 1'b0;
      wait_ready(10, seen);
      n_chk++; if (seen !== 2'b01) $display("FAIL rst_lastgrant: got %b exp 01", seen); else n_pass++;
      step(); req_valid[0] = 1'b0;
      wait_rsp(20, seen);
      wait_ready(10, seen);
      step(); req_valid = '0;
      wait_rsp(20, seen);
      n_chk++; if (seen !== 2'b10) $display("FAIL rst_tail_rsp: got %b exp 10", seen); else n_pass++;
   endtask

   task automatic test_random();
      logic [DW-1:0] ref_mem [16];
      logic [NR-1:0] acc_pend;
      int            left [NR];
      int            done, w, owner;
      bit            busy;
      logic [DW-1:0] exp_rdata;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [SW-1:0] s;
      for (int i = 0; i < 16; i++) begin init_mem[i] = $urandom; ref_mem[i] = init_mem[i]; end
      for (int i = 0; i < NR; i++) left[i] = NTX / NR;
      areset = 1'b1; req_valid = '0;
      step(); step();
      areset = 1'b0; rand_mode = 1'b1;
      exp_last = NR - 1; done = 0; busy = 1'b0; acc_pend = '0; owner = 0; exp_rdata = '0;
      for (int cyc = 0; cyc < 5000 && done < NTX; cyc++) begin
         @(negedge aclk); #1;
         req_valid = req_valid & ~acc_pend;
         acc_pend  = '0;
         for (int i = 0; i < NR; i++) begin
            if (!req_valid[i] && left[i] > 0 && $urandom_range(0, 2) == 0) begin
               set_cmd(i, 1'($urandom), 4'($urandom), $urandom, 4'($urandom));
               left[i]--;
            end
         end
         #1;
         if (req_ready != '0) begin
            w = -1;
            for (int k = 1; k <= NR; k++)
               if (w < 0 && req_valid[(exp_last + k) % NR]) w = (exp_last + k) % NR;
            n_chk++; if ({busy, req_ready} !== {1'b0, oh(w)})
               $display("FAIL rand_grant: got %b exp %b", {busy, req_ready}, {1'b0, oh(w)}); else n_pass++;
            exp_last = w; owner = w; busy = 1'b1;
            a = req_addr[w*AW +: AW]; d = req_wdata[w*DW +: DW]; s = req_wstrb[w*SW +: SW];
            if (req_write[w]) begin
               for (int b = 0; b < SW; b++) if (s[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
               exp_rdata = '0;
            end else begin
               exp_rdata = ref_mem[a];
            end
            acc_pend = req_ready;
         end
         if (rsp_valid != '0) begin
            n_chk++; if ({busy, rsp_valid, rsp_rdata, rsp_resp} !== {1'b1, oh(owner), exp_rdata, 2'b00})
               $display("FAIL rand_rsp: got %h exp %h", {busy, rsp_valid, rsp_rdata, rsp_resp},
                        {1'b1, oh(owner), exp_rdata, 2'b00}); else n_pass++;
            busy = 1'b0;
            done++;
         end
      end
      n_chk++; if (done !== NTX) $display("FAIL rand_complete: got %0d exp %0d", done, NTX); else n_pass++;
      rand_mode = 1'b0;
      req_valid = '0;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_single_read();
      test_contention();
      test_split_write();
      test_errors();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/axi_lite_req_arbiter.md
Name: axi_lite_req_arbiter

Overview:
- Shares one AXI-Lite master port between NUM_REQ simple command requesters (firmware sequencer, DMA, debug).
- Typical target: the peripheral AXI-Lite register slaves.
- Serialises single-beat reads and writes with round-robin arbitration.
- One transaction is outstanding at a time; each completion is routed back to the requester that issued it.

Parameters:
- ADDR_WIDTH, 4, AXI-Lite address width.
- DATA_WIDTH, 32, AXI-Lite data width (multiple of 8).
- NUM_REQ, 2, number of requesters (2..8).

Ports:
- aclk  input  1  clock.
- areset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester command valid; held until req_ready.
- req_ready  output  NUM_REQ  one-hot, 1-cycle accept pulse.
- req_write  input  NUM_REQ  1 = write, 0 = read.
- req_addr  input  NUM_REQ*ADDR_WIDTH  flattened; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  input  NUM_REQ*DATA_WIDTH  flattened write data.
- req_wstrb  input  NUM_REQ*DATA_WIDTH/8  flattened write strobes.
- rsp_valid  output  NUM_REQ  one-hot, 1-cycle completion pulse.
- rsp_rdata  output  DATA_WIDTH  read data; valid with rsp_valid; 0 for writes.
- rsp_resp  output  2  RRESP/BRESP of the completed transaction.
- M_AXI_LITE_awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI-Lite master channels, widths per parameters.

Behaviour:
- Reset values: all valid/ready outputs 0, all address/data/strobe/rsp outputs 0, state IDLE, last_grant = NUM_REQ-1 (requester 0 wins first).
- FSM states: IDLE, WR, WB, RA, RD, RSP.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from last_grant+1 with wrap-around.
  - req_ready[g] = 1 combinationally in that cycle only.
  - Register addr/wdata/wstrb/write and g; update last_grant = g.
  - Next state is WR for a write, RA for a read. No req_ready is asserted outside IDLE.
- WR:
  - awvalid and wvalid both assert in the cycle after the accept.
  - Each deasserts independently after its own handshake (valid & ready); aw and w may complete in either order or the same cycle.
  - Once both are done, go to WB. Payload stays stable while valid is high.
- WB: bready = 1; on bvalid, capture bresp and go to RSP.
- RA: arvalid = 1 from the cycle after the accept until arready; then RD.
- RD: rready = 1; on rvalid, capture rdata/rresp and go to RSP.
- RSP:
  - rsp_valid[g] = 1 for exactly one cycle, with rsp_rdata/rsp_resp (rdata = 0 on writes).
  - Then IDLE. The next accept occurs no earlier than the cycle after RSP.
- Minimum latency with zero-wait slave:
  - read: accept T, arvalid T+1, rvalid T+2, rsp_valid T+3.
  - write: accept T, aw/w T+1, bvalid T+2, rsp_valid T+3.
- Fairness: a requester holding req_valid is granted within NUM_REQ transactions. A requester dropping req_valid before req_ready simply loses its turn.
- rsp has no backpressure; requesters must sample rsp_valid.
- SLVERR/DECERR are passed through unchanged. There is no timeout; a hung slave stalls the block.
- Reset mid-transaction: returns to reset values next cycle and the in-flight transaction is abandoned. The connected slave must share the same reset domain.
- Address and wstrb are passed through unmodified; no alignment check.

Test Plan:
- Single write: req0 write addr 0x4, wdata 0xDEADBEEF, wstrb 0xF, zero-wait slave -> req_ready[0] at T, awaddr=0x4/wdata=0xDEADBEEF at T+1, rsp_valid=01 at T+3, rsp_resp=0, rsp_rdata=0.
- Single read: req1 read addr 0x8, slave returns 0x12345678 after 3 wait cycles -> rsp_valid=10, rsp_rdata=0x12345678, rsp_resp=0.
- Contention: both requesters valid continuously, reads to addrs 0x0 and 0xC -> grants alternate 0,1,0,1; no requester granted twice in a row.
- Split write handshake: awready at T+1 but wready only at T+4 -> awvalid drops after T+1, wvalid held T+1..T+4, bready only after T+4, data stable throughout.
- Error pass-through: slave returns bresp=2'b10 on write, rresp=2'b11 on read -> rsp_resp 2 and 3 respectively on the correct rsp_valid bit.
- Reset in RD state (rvalid withheld) -> next cycle all outputs 0, state IDLE; a pending req1 is then granted before req0 only if req0 is idle, since last_grant resets to NUM_REQ-1.
